// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared constants for the bus transfer controller and the GPR bank top level.
// Holds the FSM state encoding and the default bus geometry.
package bus_xfer_ctrl_pkg;

  localparam int unsigned DefaultWidth   = 8;
  localparam int unsigned DefaultNumRegs = 4;
  localparam int unsigned DefaultIdxW    = 2;

  // Transfer FSM encoding, kept as plain constants for legacy users.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request/completion handshake plus GPR bus wiring for bus_xfer_ctrl.
//   master : requester and GPR bank side (drives req_*, reg_bus)
//   slave  : controller side (drives req_ready, enables, bus_drv, done/err)
interface bus_xfer_ctrl_if
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned IDX_W    = DefaultIdxW
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_imm;
  logic [IDX_W-1:0]          req_src;
  logic [IDX_W-1:0]          req_dst;
  logic [WIDTH-1:0]          req_data;
  logic [NUM_REGS*WIDTH-1:0] reg_bus;
  logic [NUM_REGS-1:0]       out_en;
  logic [NUM_REGS-1:0]       load_en;
  logic [WIDTH-1:0]          bus_drv;
  logic                      done;
  logic [WIDTH-1:0]          done_data;
  logic                      err;

  modport master (
    output req_valid, req_imm, req_src, req_dst, req_data, reg_bus,
    input  req_ready, out_en, load_en, bus_drv, done, done_data, err
  );

  modport slave (
    input  req_valid, req_imm, req_src, req_dst, req_data, reg_bus,
    output req_ready, out_en, load_en, bus_drv, done, done_data, err
  );

endinterface

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable. Out-of-range indices decode to zero.
//   en     : decoder enable
//   idx    : register index
//   onehot : one-hot-or-zero select vector
module onehot_dec
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned IDX_W    = DefaultIdxW
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus-side initiator for the GPR bank. Accepts register or immediate moves,
// sequences source out_en and destination load_en, drives the shared bus_in
// net and reports completion (with err for an invalid index).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request/completion handshake and GPR bus signals (slave side)
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned IDX_W    = DefaultIdxW
) (
  input logic            clk,
  input logic            reset,
  bus_xfer_ctrl_if.slave bus
);

  logic [1:0]          state_q, state_d;
  logic                imm_q, imm_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                err_q;
  logic [WIDTH-1:0]    done_data_q;
  logic [NUM_REGS-1:0] out_en_q, out_en_d;
  logic [NUM_REGS-1:0] load_en_q, load_en_d;
  logic [WIDTH-1:0]    reg_or;
  logic                accept;
  logic                idx_ok;

  assign accept = (state_q == StIdle) && bus.req_valid;
  assign idx_ok = (bus.req_imm || (32'(bus.req_src) < NUM_REGS)) &&
                  (32'(bus.req_dst) < NUM_REGS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = idx_ok ? StDrive : StDone;
      StDrive: state_d = StLoad;
      StLoad:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign imm_d  = accept ? bus.req_imm  : imm_q;
  assign src_d  = accept ? bus.req_src  : src_q;
  assign dst_d  = accept ? bus.req_dst  : dst_q;
  assign data_d = accept ? bus.req_data : data_q;

  // Enables decode from next-state so the registered outputs line up with
  // the state they belong to and never glitch.
  onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_out_dec (
    .en     (((state_d == StDrive) || (state_d == StLoad)) && !imm_d),
    .idx    (src_d),
    .onehot (out_en_d)
  );

  onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_load_dec (
    .en     (state_d == StLoad),
    .idx    (dst_d),
    .onehot (load_en_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      imm_q       <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      done_data_q <= '0;
      out_en_q    <= '0;
      load_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      imm_q     <= imm_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      out_en_q  <= out_en_d;
      load_en_q <= load_en_d;
      if (accept) err_q <= !idx_ok;
      // Same edge at which the destination GPR captures bus_drv.
      if (state_q == StLoad) done_data_q <= bus.bus_drv;
    end
  end

  // Disabled GPRs drive zero, so the OR of all slices is the selected source.
  always_comb begin
    reg_or = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_or = reg_or | bus.reg_bus[i*WIDTH +: WIDTH];
    end
  end

  assign bus.bus_drv   = imm_q ? data_q : reg_or;
  assign bus.req_ready = (state_q == StIdle);
  assign bus.out_en    = out_en_q;
  assign bus.load_en   = load_en_q;
  assign bus.done      = (state_q == StDone);
  assign bus.err       = (state_q == StDone) && err_q;
  assign bus.done_data = done_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a 4-register build with behavioural GPRs on the
// bus, plus a 3-register build for the invalid-index case.
module tb_bus_xfer_ctrl;
  import bus_xfer_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.NUM_REGS(4), .WIDTH(8), .IDX_W(2)) ifa ();
  bus_xfer_ctrl_if #(.NUM_REGS(3), .WIDTH(8), .IDX_W(2)) ifb ();

  bus_xfer_ctrl #(.NUM_REGS(4), .WIDTH(8), .IDX_W(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  bus_xfer_ctrl #(.NUM_REGS(3), .WIDTH(8), .IDX_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Behavioural GPR banks: not reset by the controller reset.
  logic [7:0] gpr_a [4] = '{default: 8'h00};
  logic [7:0] gpr_b [3] = '{default: 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (ifa.load_en[i]) gpr_a[i] <= ifa.bus_drv;
    for (int i = 0; i < 3; i++) if (ifb.load_en[i]) gpr_b[i] <= ifb.bus_drv;
  end

  always_comb begin
    ifa.reg_bus = '0;
    for (int i = 0; i < 4; i++) ifa.reg_bus[i*8 +: 8] = ifa.out_en[i] ? gpr_a[i] : 8'h00;
  end

  always_comb begin
    ifb.reg_bus = '0;
    for (int i = 0; i < 3; i++) ifb.reg_bus[i*8 +: 8] = ifb.out_en[i] ? gpr_b[i] : 8'h00;
  end

  // Reference: architectural register contents of the 4-register bank.
  logic [7:0] model_a [4] = '{default: 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank_a(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, 32'(gpr_a[i]), 32'(model_a[i]));
  endtask

  // One full transfer on dut_a; called at a negedge with the controller idle.
  task automatic xfer_a(input logic imm, input logic [1:0] src, input logic [1:0] dst,
                        input logic [7:0] data);
    logic [7:0] val;
    logic [3:0] src_oh;
    logic [3:0] dst_oh;
    val    = imm ? data : model_a[src];
    src_oh = imm ? 4'b0000 : 4'(1 << src);
    dst_oh = 4'(1 << dst);
    chk("idle_ready", 32'(ifa.req_ready), 32'd1);
    ifa.req_valid = 1'b1;
    ifa.req_imm   = imm;
    ifa.req_src   = src;
    ifa.req_dst   = dst;
    ifa.req_data  = data;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    ifa.req_data  = 8'($urandom_range(0, 255));
    chk("drive_ready", 32'(ifa.req_ready), 32'd0);
    chk("drive_out_en", 32'(ifa.out_en), 32'(src_oh));
    chk("drive_load_en", 32'(ifa.load_en), 32'd0);
    chk("drive_done", 32'(ifa.done), 32'd0);
    @(negedge clk);
    chk("load_out_en", 32'(ifa.out_en), 32'(src_oh));
    chk("load_load_en", 32'(ifa.load_en), 32'(dst_oh));
    chk("load_bus_drv", 32'(ifa.bus_drv), 32'(val));
    @(negedge clk);
    model_a[dst] = val;
    chk("done_pulse", 32'(ifa.done), 32'd1);
    chk("done_err", 32'(ifa.err), 32'd0);
    chk("done_data", 32'(ifa.done_data), 32'(val));
    chk("done_enables", 32'({ifa.out_en, ifa.load_en}), 32'd0);
    chk_bank_a("bank_a");
    @(negedge clk);
    chk("post_done", 32'(ifa.done), 32'd0);
    chk("post_ready", 32'(ifa.req_ready), 32'd1);
    chk("post_data_hold", 32'(ifa.done_data), 32'(val));
  endtask

  initial begin
    logic [7:0] exp_q [$];
    logic [7:0] val;
    logic [1:0] s, d;
    logic       im;
    int issued, dones, last_done, busy;

    ifa.req_valid = 1'b0; ifa.req_imm = 1'b0; ifa.req_src = '0; ifa.req_dst = '0;
    ifa.req_data  = '0;
    ifb.req_valid = 1'b0; ifb.req_imm = 1'b0; ifb.req_src = '0; ifb.req_dst = '0;
    ifb.req_data  = '0;

    // Reset for two cycles, then release.
    @(negedge clk);
    chk("rst_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_enables", 32'({ifa.out_en, ifa.load_en}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ifa.req_ready), 32'd1);
    chk("rel_enables", 32'({ifa.out_en, ifa.load_en}), 32'd0);
    chk("rel_done_err", 32'({ifa.done, ifa.err}), 32'd0);
    chk("rel_bus_drv", 32'(ifa.bus_drv), 32'd0);
    chk("rel_done_data", 32'(ifa.done_data), 32'd0);

    // Directed moves: immediate, register, self-move.
    xfer_a(1'b1, 2'd0, 2'd1, 8'hA5);
    xfer_a(1'b0, 2'd1, 2'd3, 8'h00);
    xfer_a(1'b1, 2'd2, 2'd0, 8'h3E);
    xfer_a(1'b0, 2'd0, 2'd0, 8'hFF);

    // Random moves against the register model.
    for (int n = 0; n < 16; n++) begin
      xfer_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)));
    end

    // req_valid held high across three back-to-back requests.
    issued = 0; dones = 0; last_done = -1; busy = 0;
    ifa.req_valid = 1'b1;
    for (int c = -1; c < 14; c++) begin
      if (c >= 0) begin
        @(negedge clk);
        if (!ifa.req_ready) busy++;
        if (ifa.done) begin
          if (exp_q.size() > 0) chk("b2b_data", 32'(ifa.done_data), 32'(exp_q.pop_front()));
          else chk("b2b_extra_done", 32'(ifa.done), 32'd0);
          if (last_done >= 0) chk("b2b_spacing", 32'(c - last_done), 32'd4);
          last_done = c;
          dones++;
        end
      end
      if (ifa.req_ready) begin
        if (issued < 3) begin
          im = 1'($urandom_range(0, 1));
          s  = 2'($urandom_range(0, 3));
          d  = 2'($urandom_range(0, 3));
          ifa.req_imm  = im;
          ifa.req_src  = s;
          ifa.req_dst  = d;
          ifa.req_data = 8'($urandom_range(0, 255));
          val = im ? ifa.req_data : model_a[s];
          model_a[d] = val;
          exp_q.push_back(val);
          issued++;
        end else begin
          ifa.req_valid = 1'b0;
        end
      end
    end
    ifa.req_valid = 1'b0;
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_busy_cycles", 32'(busy), 32'd9);
    chk_bank_a("b2b_bank");

    // Invalid indices on the 3-register build.
    chk("b_rst_done_data", 32'(ifb.done_data), 32'd0);
    for (int k = 0; k < 2; k++) begin
      ifb.req_valid = 1'b1;
      ifb.req_imm   = (k == 0);
      ifb.req_src   = (k == 0) ? 2'd0 : 2'd3;
      ifb.req_dst   = (k == 0) ? 2'd3 : 2'd0;
      ifb.req_data  = 8'h5A;
      @(negedge clk);
      ifb.req_valid = 1'b0;
      chk("inv_done", 32'(ifb.done), 32'd1);
      chk("inv_err", 32'(ifb.err), 32'd1);
      chk("inv_enables", 32'({ifb.out_en, ifb.load_en}), 32'd0);
      chk("inv_done_data", 32'(ifb.done_data), 32'd0);
      @(negedge clk);
      chk("inv_after", 32'({ifb.done, ifb.err, ifb.req_ready}), 32'b001);
      for (int i = 0; i < 3; i++) chk("inv_bank", 32'(gpr_b[i]), 32'd0);
    end
    // A valid move afterwards completes without err.
    ifb.req_valid = 1'b1; ifb.req_imm = 1'b1; ifb.req_dst = 2'd2; ifb.req_data = 8'h77;
    @(negedge clk);
    ifb.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_ok_done_err", 32'({ifb.done, ifb.err}), 32'b10);
    chk("b_ok_data", 32'(ifb.done_data), 32'h77);
    chk("b_ok_bank", 32'(gpr_b[2]), 32'h77);
    @(negedge clk);

    // Reset during LOAD of an immediate 3C -> r3 (r3 holds 12 beforehand).
    xfer_a(1'b1, 2'd0, 2'd3, 8'h12);
    ifa.req_valid = 1'b1; ifa.req_imm = 1'b1; ifa.req_dst = 2'd3; ifa.req_data = 8'h3C;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_load_en", 32'(ifa.load_en), 32'b1000);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_enables", 32'({ifa.out_en, ifa.load_en}), 32'd0);
    chk("mid_rst_ready", 32'(ifa.req_ready), 32'd1);
    chk("mid_rst_done", 32'(ifa.done), 32'd0);
    @(negedge clk);
    chk("mid_rst_r3", 32'(gpr_a[3]), 32'h12);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(ifa.req_ready), 32'd1);
    chk("mid_rel_done", 32'(ifa.done), 32'd0);
    chk_bank_a("mid_bank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
